// File: rtl/mips_dump_unit.sv
// Debug read-out engine: walks the MIPS debug selectors and streams PC, ALU result,
// registers and data memory as an A5 ... 5A byte frame over a valid/ready handshake.
module mips_dump_unit #(
    parameter int unsigned NB          = 32,
    parameter int unsigned NB_REGS     = 5,
    parameter int unsigned N_REGS      = 32,
    parameter int unsigned N_MEM_WORDS = 16,
    parameter int unsigned NB_BYTE     = 8
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_start,
    input  logic [NB-1:0]      i_mips_pc,
    input  logic [NB-1:0]      i_mips_alu_result,
    input  logic [NB-1:0]      i_mips_register_data,
    input  logic [NB-1:0]      i_mips_data_memory,
    output logic [NB_REGS-1:0] o_debug_mips_register_number,
    output logic [NB-1:0]      o_debug_address,
    output logic [NB_BYTE-1:0] o_tx_data,
    output logic               o_tx_valid,
    input  logic               i_tx_ready,
    output logic               o_busy,
    output logic               o_done
);

    localparam int unsigned ITEMS     = 2 + N_REGS + N_MEM_WORDS;
    localparam int unsigned IW        = $clog2(ITEMS);
    localparam int unsigned BPW       = NB / NB_BYTE;
    localparam int unsigned CW        = (BPW > 1) ? $clog2(BPW) : 1;
    localparam int unsigned FIRST_MEM = 2 + N_REGS;

    localparam logic [NB_BYTE-1:0] HEADER_BYTE  = NB_BYTE'(8'hA5);
    localparam logic [NB_BYTE-1:0] TRAILER_BYTE = NB_BYTE'(8'h5A);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_HEADER  = 3'd1;
    localparam logic [2:0] S_SETTLE  = 3'd2;
    localparam logic [2:0] S_LOAD    = 3'd3;
    localparam logic [2:0] S_SEND    = 3'd4;
    localparam logic [2:0] S_TRAILER = 3'd5;
    localparam logic [2:0] S_DONE    = 3'd6;

    logic [2:0]         state, state_next;
    logic [IW-1:0]      item, item_next, sel_item;
    logic [CW-1:0]      cnt, cnt_next;
    logic [NB-1:0]      shreg, shreg_next, word_sel;
    logic [NB_BYTE-1:0] data_next;
    logic               valid_next, busy_next, done_next, select_now;
    logic [NB_REGS-1:0] reg_num_next;
    logic [NB-1:0]      addr_next;

    // Word presented by the pipeline for the current item
    always_comb begin
        if (item == '0)
            word_sel = i_mips_pc;
        else if (item == IW'(1))
            word_sel = i_mips_alu_result;
        else if (item < IW'(FIRST_MEM))
            word_sel = i_mips_register_data;
        else
            word_sel = i_mips_data_memory;
    end

    always_comb begin
        state_next   = state;
        item_next    = item;
        cnt_next     = cnt;
        shreg_next   = shreg;
        data_next    = o_tx_data;
        valid_next   = o_tx_valid;
        busy_next    = o_busy;
        done_next    = 1'b0;
        reg_num_next = o_debug_mips_register_number;
        addr_next    = o_debug_address;
        sel_item     = item;
        select_now   = 1'b0;

        case (state)
            S_IDLE: begin
                if (i_start) begin
                    state_next = S_HEADER;
                    item_next  = '0;
                    busy_next  = 1'b1;
                    valid_next = 1'b1;
                    data_next  = HEADER_BYTE;
                end
            end
            S_HEADER: begin
                if (i_tx_ready) begin
                    state_next = S_SETTLE;
                    valid_next = 1'b0;
                    select_now = 1'b1;
                end
            end
            S_SETTLE: state_next = S_LOAD;
            S_LOAD: begin
                state_next = S_SEND;
                shreg_next = word_sel;
                cnt_next   = '0;
                data_next  = word_sel[NB-1 -: NB_BYTE];
                valid_next = 1'b1;
            end
            S_SEND: begin
                if (i_tx_ready) begin
                    shreg_next = shreg << NB_BYTE;
                    cnt_next   = cnt + CW'(1);
                    data_next  = shreg[NB-NB_BYTE-1 -: NB_BYTE];
                    if (cnt == CW'(BPW - 1)) begin
                        if (item == IW'(ITEMS - 1)) begin
                            state_next = S_TRAILER;
                            data_next  = TRAILER_BYTE;
                        end else begin
                            state_next = S_SETTLE;
                            valid_next = 1'b0;
                            item_next  = item + IW'(1);
                            sel_item   = item + IW'(1);
                            select_now = 1'b1;
                        end
                    end
                end
            end
            S_TRAILER: begin
                if (i_tx_ready) begin
                    state_next = S_DONE;
                    valid_next = 1'b0;
                    done_next  = 1'b1;
                end
            end
            S_DONE: begin
                state_next = S_IDLE;
                busy_next  = 1'b0;
            end
            default: state_next = S_IDLE;
        endcase

        // Selectors change only when entering SETTLE, so they stay put through SEND
        if (select_now) begin
            if (sel_item >= IW'(2) && sel_item < IW'(FIRST_MEM))
                reg_num_next = NB_REGS'(sel_item - IW'(2));
            else
                reg_num_next = '0;
            if (sel_item >= IW'(FIRST_MEM))
                addr_next = NB'(sel_item - IW'(FIRST_MEM)) << 2;
            else
                addr_next = '0;
        end
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state                        <= S_IDLE;
            item                         <= '0;
            cnt                          <= '0;
            shreg                        <= '0;
            o_tx_data                    <= '0;
            o_tx_valid                   <= 1'b0;
            o_busy                       <= 1'b0;
            o_done                       <= 1'b0;
            o_debug_mips_register_number <= '0;
            o_debug_address              <= '0;
        end else begin
            state                        <= state_next;
            item                         <= item_next;
            cnt                          <= cnt_next;
            shreg                        <= shreg_next;
            o_tx_data                    <= data_next;
            o_tx_valid                   <= valid_next;
            o_busy                       <= busy_next;
            o_done                       <= done_next;
            o_debug_mips_register_number <= reg_num_next;
            o_debug_address              <= addr_next;
        end
    end

endmodule
